// File: rtl/memory_stage_if.sv
// EX/MEM request bus plus MEM/WB result and stall back-pressure for memory_stage.
interface memory_stage_if #(
  parameter int unsigned DATA_W = 16
);
  logic [69:0]       exmem_bus;
  logic              stall;
  logic              wb_en;
  logic [2:0]        wb_addr;
  logic [DATA_W-1:0] wb_data;

  modport master (output exmem_bus, input stall, wb_en, wb_addr, wb_data);
  modport slave  (input exmem_bus, output stall, wb_en, wb_addr, wb_data);
endinterface

// File: rtl/memory_stage.sv
// MEM pipeline stage: decodes EX/MEM, runs loads/stores on an internal RAM with
// configurable latency, registers the MEM/WB write-back and stalls upstream while busy.
module memory_stage #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  memory_stage_if.slave    bus
);
  localparam int unsigned CNT_W = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY - 1) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        req_dst_q, req_dst_d;
  logic              req_wb_q, req_wb_d;
  logic              req_mw_q, req_mw_d;
  logic              req_mr_q, req_mr_d;
  logic [DATA_W-1:0] req_data_q, req_data_d;
  logic [ADDR_W-1:0] req_idx_q, req_idx_d;
  logic              wb_en_q, wb_en_d;
  logic [2:0]        wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic [2:0]        cur_dst;
  logic              cur_wb, cur_mw, cur_mr;
  logic [DATA_W-1:0] cur_data;
  logic [ADDR_W-1:0] cur_idx;
  logic              complete, mem_we, stall_c;
  logic              unused_bits;

  assign unused_bits = ^{bus.exmem_bus[63:32+DATA_W], bus.exmem_bus[31:ADDR_W]};

  // While BUSY the latched request is authoritative; the live bus is ignored.
  always_comb begin
    if (state_q == BUSY) begin
      cur_dst  = req_dst_q;
      cur_wb   = req_wb_q;
      cur_mw   = req_mw_q;
      cur_mr   = req_mr_q;
      cur_data = req_data_q;
      cur_idx  = req_idx_q;
    end else begin
      cur_dst  = bus.exmem_bus[69:67];
      cur_wb   = bus.exmem_bus[66];
      cur_mw   = bus.exmem_bus[65];
      cur_mr   = bus.exmem_bus[64];
      cur_data = bus.exmem_bus[32 +: DATA_W];
      cur_idx  = bus.exmem_bus[ADDR_W-1:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_dst_d  = req_dst_q;
    req_wb_d   = req_wb_q;
    req_mw_d   = req_mw_q;
    req_mr_d   = req_mr_q;
    req_data_d = req_data_q;
    req_idx_d  = req_idx_q;
    wb_en_d    = wb_en_q;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    complete   = 1'b0;
    stall_c    = 1'b0;

    case (state_q)
      IDLE: begin
        if (!(cur_mr || cur_mw)) begin
          wb_en_d   = cur_wb;
          wb_addr_d = cur_dst;
          wb_data_d = cur_data;
        end else if (MEM_LATENCY == 1) begin
          complete = 1'b1;
        end else begin
          stall_c    = 1'b1;
          state_d    = BUSY;
          cnt_d      = CNT_W'(MEM_LATENCY - 2);
          wb_en_d    = 1'b0;
          req_dst_d  = cur_dst;
          req_wb_d   = cur_wb;
          req_mw_d   = cur_mw;
          req_mr_d   = cur_mr;
          req_data_d = cur_data;
          req_idx_d  = cur_idx;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          stall_c = 1'b1;
          cnt_d   = cnt_q - 1'b1;
          wb_en_d = 1'b0;
        end else begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (complete) begin
      wb_en_d   = cur_wb;
      wb_addr_d = cur_dst;
      wb_data_d = cur_mw ? cur_data : mem[cur_idx];
    end
  end

  // Gating with rst_n keeps an in-reset edge from committing a store.
  assign mem_we = complete && cur_mw && rst_n;

  always_ff @(posedge clk) begin
    if (mem_we) mem[cur_idx] <= cur_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      req_dst_q  <= '0;
      req_wb_q   <= 1'b0;
      req_mw_q   <= 1'b0;
      req_mr_q   <= 1'b0;
      req_data_q <= '0;
      req_idx_q  <= '0;
      wb_en_q    <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_dst_q  <= req_dst_d;
      req_wb_q   <= req_wb_d;
      req_mw_q   <= req_mw_d;
      req_mr_q   <= req_mr_d;
      req_data_q <= req_data_d;
      req_idx_q  <= req_idx_d;
      wb_en_q    <= wb_en_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign bus.stall   = stall_c && rst_n;
  assign bus.wb_en   = wb_en_q;
  assign bus.wb_addr = wb_addr_q;
  assign bus.wb_data = wb_data_q;
endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: three instances (latency 1, 2, 4) driven by a directed
// vector table, reset/abort sequences and random ops checked against a memory model.
module tb_memory_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [69:0] bus_in [3];
  logic        stall_w [3];
  logic        wb_en_w [3];
  logic [2:0]  wb_addr_w [3];
  logic [15:0] wb_data_w [3];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    memory_stage_if #(.DATA_W(16)) ifc ();
    assign ifc.exmem_bus = bus_in[g];
    assign stall_w[g]    = ifc.stall;
    assign wb_en_w[g]    = ifc.wb_en;
    assign wb_addr_w[g]  = ifc.wb_addr;
    assign wb_data_w[g]  = ifc.wb_data;
    memory_stage #(
      .DATA_W(16),
      .ADDR_W(10),
      .MEM_LATENCY((g == 0) ? 1 : (g == 1) ? 2 : 4)
    ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (ifc.slave)
    );
  end

  function automatic int lat(input int k);
    return (k == 0) ? 1 : (k == 1) ? 2 : 4;
  endfunction

  typedef struct {
    logic [2:0]  dst;
    logic        wb, mw, mr;
    logic [31:0] data, addr;
    logic        e_en;
    logic [2:0]  e_addr;
    logic [15:0] e_data;
  } vec_t;

  vec_t tbl [10];

  // Reference memory: contents and which words have been written.
  logic [15:0] mdl [3][1024];
  bit          mv  [3][1024];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp_v);
    end
  endtask

  task automatic mdl_apply(input int k, input logic mw, input logic [31:0] data, input logic [31:0] addr);
    if (mw) begin
      mdl[k][addr[9:0]] = data[15:0];
      mv[k][addr[9:0]]  = 1'b1;
    end
  endtask

  task automatic run_op(input int k, input logic [2:0] dst, input logic wb, input logic mw,
                        input logic mr, input logic [31:0] data, input logic [31:0] addr,
                        input logic e_en, input logic [2:0] e_addr, input logic [15:0] e_data);
    int n;
    int e_stall;
    e_stall = (mw || mr) ? lat(k) - 1 : 0;
    @(negedge clk);
    bus_in[k] = {dst, wb, mw, mr, data, addr};
    #1;
    n = 0;
    while (stall_w[k] === 1'b1 && n < 20) begin
      @(posedge clk); #1;
      chk("wb_en_low_in_stall", 32'(wb_en_w[k]), 32'd0);
      n++;
    end
    chk("stall_cycles", n, e_stall);
    @(posedge clk); #1;
    chk("wb_en", 32'(wb_en_w[k]), 32'(e_en));
    chk("wb_addr", 32'(wb_addr_w[k]), 32'(e_addr));
    chk("wb_data", 32'(wb_data_w[k]), 32'(e_data));
    mdl_apply(k, mw, data, addr);
  endtask

  task automatic chk_reset_outs(input string nm);
    for (int k = 0; k < 3; k++) begin
      chk({nm, "_stall"}, 32'(stall_w[k]), 32'd0);
      chk({nm, "_wb_en"}, 32'(wb_en_w[k]), 32'd0);
      chk({nm, "_wb_addr"}, 32'(wb_addr_w[k]), 32'd0);
      chk({nm, "_wb_data"}, 32'(wb_data_w[k]), 32'd0);
    end
  endtask

  initial begin
    tbl[0] = '{3'd5, 1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'd0,           1'b1, 3'd5, 16'h1234};
    tbl[1] = '{3'd0, 1'b0, 1'b1, 1'b0, 32'h0000_BEEF, 32'd13,          1'b0, 3'd0, 16'hBEEF};
    tbl[2] = '{3'd7, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 32'd13,          1'b1, 3'd7, 16'hBEEF};
    tbl[3] = '{3'd0, 1'b0, 1'b1, 1'b0, 32'h0000_A5A5, 32'd13 + 32'd1024, 1'b0, 3'd0, 16'hA5A5};
    tbl[4] = '{3'd2, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 32'd13,          1'b1, 3'd2, 16'hA5A5};
    tbl[5] = '{3'd3, 1'b1, 1'b1, 1'b1, 32'h0000_0F0F, 32'd40,          1'b1, 3'd3, 16'h0F0F};
    tbl[6] = '{3'd4, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 32'd40,          1'b1, 3'd4, 16'h0F0F};
    tbl[7] = '{3'd6, 1'b0, 1'b0, 1'b0, 32'h55AA_7777, 32'd9,           1'b0, 3'd6, 16'h7777};
    tbl[8] = '{3'd1, 1'b0, 1'b1, 1'b0, 32'hDEAD_C0DE, 32'hFFFF_0064,   1'b0, 3'd1, 16'hC0DE};
    tbl[9] = '{3'd1, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 32'd100,         1'b1, 3'd1, 16'hC0DE};

    for (int k = 0; k < 3; k++) begin
      bus_in[k] = '0;
      for (int a = 0; a < 1024; a++) mv[k][a] = 1'b0;
    end

    #12;
    chk_reset_outs("reset_init");
    #5 rst_n = 1'b1;

    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 10; i++)
        run_op(k, tbl[i].dst, tbl[i].wb, tbl[i].mw, tbl[i].mr, tbl[i].data, tbl[i].addr,
               tbl[i].e_en, tbl[i].e_addr, tbl[i].e_data);

    // Async reset mid-cycle while dut2 is busy with a load.
    @(negedge clk);
    bus_in[2] = {3'd5, 1'b1, 1'b0, 1'b1, 32'd0, 32'd13};
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outs("reset_async");
    bus_in[2] = '0;
    #1 rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("reset_no_pulse", 32'(wb_en_w[2]), 32'd0);
    end

    // Abort in the IDLE stall cycle of a latency-2 store.
    run_op(1, 3'd0, 1'b0, 1'b1, 1'b0, 32'h1111, 32'd20, 1'b0, 3'd0, 16'h1111);
    @(negedge clk);
    bus_in[1] = {3'd0, 1'b0, 1'b1, 1'b0, 32'h2222, 32'd20};
    #1 chk("abort1_stall", 32'(stall_w[1]), 32'd1);
    #1 rst_n = 1'b0;
    #1 chk_reset_outs("abort1");
    bus_in[1] = '0;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort1_no_pulse", 32'(wb_en_w[1]), 32'd0);
    run_op(1, 3'd6, 1'b1, 1'b0, 1'b1, 32'd0, 32'd20, 1'b1, 3'd6, 16'h1111);

    // Abort while BUSY with countdown pending on the latency-4 instance.
    run_op(2, 3'd0, 1'b0, 1'b1, 1'b0, 32'h4444, 32'd21, 1'b0, 3'd0, 16'h4444);
    @(negedge clk);
    bus_in[2] = {3'd0, 1'b1, 1'b1, 1'b0, 32'h3333, 32'd21};
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0;
    #1 chk_reset_outs("abort2");
    bus_in[2] = '0;
    #1 rst_n = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("abort2_no_pulse", 32'(wb_en_w[2]), 32'd0);
    end
    run_op(2, 3'd2, 1'b1, 1'b0, 1'b1, 32'd0, 32'd21, 1'b1, 3'd2, 16'h4444);

    // Random traffic checked against the reference memory.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 60; i++) begin
        logic [2:0]  dst;
        logic        wb, mw, mr;
        logic [31:0] data, addr;
        logic [15:0] e_data;
        int          kind;
        kind = int'($urandom_range(0, 3));
        dst  = 3'($urandom);
        wb   = 1'($urandom);
        data = $urandom;
        addr = {$urandom_range(0, 255) << 10} | 32'($urandom_range(0, 31));
        mw   = (kind == 1) || (kind == 3);
        mr   = (kind == 2) || (kind == 3);
        if (kind == 2 && !mv[k][addr[9:0]]) begin
          mw = 1'b1;
          mr = 1'b0;
        end
        if (mw || !mr) e_data = data[15:0];
        else           e_data = mdl[k][addr[9:0]];
        run_op(k, dst, wb, mw, mr, data, addr, wb, dst, e_data);
      end
      @(negedge clk);
      bus_in[k] = '0;
    end

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
